// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int PC_W        = 32;
  localparam int IADDR_W     = 30;
  localparam int STALL_CNT_W = 16;

  localparam logic [PC_W-1:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Action applied to the PC registers at the next edge
  typedef enum logic [1:0] {
    UPD_HOLD = 2'd0,
    UPD_ADV  = 2'd1,
    UPD_KILL = 2'd2
  } pc_upd_e;

  // Word address of a byte PC
  function automatic logic [IADDR_W-1:0] word_addr(input logic [PC_W-1:0] pc);
    return pc[PC_W-1:2];
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: program memory port, redirect input and decode handshake.
interface ifu_if
  import ifu_pkg::*;
();
  logic [IADDR_W-1:0] imem_addr;
  logic [PC_W-1:0]    imem_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [PC_W-1:0]    id_instr;
  logic [PC_W-1:0]    id_pc;
  logic [PC_W-1:0]    id_pc_plus4;
  logic               id_fault;

  // Fetch unit side
  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_fault,
    input  imem_data, redirect_valid, redirect_pc, id_ready
  );

  // Memory / decode / branch-resolution side
  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_fault,
    output imem_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instruction_fetch_unit_pc_reg.sv
// PC state: next PC to issue, PC of the word on imem_data and its valid bit.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  pc_upd_e            upd,
  input  logic [PC_W-1:0]    tgt_pc,   // already word aligned
  output logic [IADDR_W-1:0] pc_word,
  output logic [PC_W-1:0]    rsp_pc,
  output logic               rsp_v
);
  logic [PC_W-1:0] pc_q;

  assign pc_word = word_addr(pc_q);

  // Redirect beats advance; otherwise hold so the stalled pair stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      rsp_pc <= RESET_PC;
      rsp_v  <= 1'b0;
    end else begin
      case (upd)
        UPD_KILL: begin
          rsp_pc <= tgt_pc;
          pc_q   <= tgt_pc + 32'd4;
          rsp_v  <= 1'b1;
        end
        UPD_ADV: begin
          rsp_pc <= pc_q;
          pc_q   <= pc_q + 32'd4;
          rsp_v  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC generation / fetch stage in front of a 1-cycle synchronous program memory.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              IMEM_DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ifu_if.master                  bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam logic [IADDR_W:0] DEPTH = IMEM_DEPTH[IADDR_W:0];

  logic               kill, adv, id_valid, id_fault;
  pc_upd_e            upd;
  logic [PC_W-1:0]    tgt_pc, rsp_pc;
  logic [IADDR_W-1:0] pc_word;
  logic               rsp_v;

  assign tgt_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  assign kill   = bus.redirect_valid;
  assign adv    = !rsp_v || bus.id_ready;

  // Select the PC register update for this cycle
  always_comb begin
    upd = UPD_HOLD;
    if (kill)     upd = UPD_KILL;
    else if (adv) upd = UPD_ADV;
  end

  ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd     (upd),
    .tgt_pc  (tgt_pc),
    .pc_word (pc_word),
    .rsp_pc  (rsp_pc),
    .rsp_v   (rsp_v)
  );

  // Memory address: stall re-reads the held word so imem_data stays stable
  always_comb begin
    bus.imem_addr = word_addr(rsp_pc);
    if (kill)     bus.imem_addr = word_addr(tgt_pc);
    else if (adv) bus.imem_addr = pc_word;
  end

  assign id_valid        = rsp_v && !kill;
  assign id_fault        = rsp_v && ({1'b0, word_addr(rsp_pc)} >= DEPTH);
  assign bus.id_valid    = id_valid;
  assign bus.id_fault    = id_fault;
  assign bus.id_instr    = id_fault ? NOP_INSTR : bus.imem_data;
  assign bus.id_pc       = rsp_pc;
  assign bus.id_pc_plus4 = rsp_pc + 32'd4;

  // Saturating count of cycles decode held off a valid pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (id_valid && !bus.id_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed table, random stream, async reset.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] stall_cnt;

  ifu_if bus ();

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Program memory: word n holds A000_0000 + n, one cycle read latency
  always @(posedge clk) bus.imem_data <= 32'hA000_0000 + {2'b00, bus.imem_addr};

  int nvec = 0;
  int nmis = 0;

  // Reference: PC of the pair that should be presented, whether one is pending
  logic        have;
  logic [31:0] mpc;
  logic [15:0] mcnt;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        efault;
    logic [29:0] eaddr;
    logic [15:0] est;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                         input logic ef, input logic [29:0] ea, input logic [15:0] est);
    chk("id_valid", {31'd0, bus.id_valid}, {31'd0, ev});
    chk("imem_addr", {2'b00, bus.imem_addr}, {2'b00, ea});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, est});
    if (ev) begin
      chk("id_pc", bus.id_pc, epc);
      chk("id_pc_plus4", bus.id_pc_plus4, epc + 32'd4);
      chk("id_instr", bus.id_instr, ei);
      chk("id_fault", {31'd0, bus.id_fault}, {31'd0, ef});
    end
  endtask

  function automatic logic m_fault(input logic [31:0] pc);
    return pc[31:2] >= 30'd32;
  endfunction

  function automatic logic [31:0] m_instr(input logic [31:0] pc);
    return m_fault(pc) ? 32'h0 : 32'hA000_0000 + {2'b00, pc[31:2]};
  endfunction

  function automatic logic [29:0] m_addr(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] nxt;
    if (rv) return rpc[31:2];
    if (have && !rdy) return mpc[31:2];
    nxt = have ? mpc + 32'd4 : mpc;
    return nxt[31:2];
  endfunction

  task automatic m_reset();
    have = 1'b0;
    mpc  = 32'h0;
    mcnt = 16'h0;
  endtask

  task automatic m_edge(input logic rv, input logic [31:0] rpc, input logic rdy);
    if (have && !rv && !rdy && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    if (rv) begin
      mpc  = {rpc[31:2], 2'b00};
      have = 1'b1;
    end else if (!have) begin
      have = 1'b1;
    end else if (rdy) begin
      mpc = mpc + 32'd4;
    end
  endtask

  // One cycle: drive at negedge, check after settle, advance model, wait next negedge
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy, input bit use_model);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.id_ready       = rdy;
    #1;
    if (use_model)
      chk_out(have && !rv, mpc, m_instr(mpc), m_fault(mpc), m_addr(rv, rpc, rdy), mcnt);
    m_edge(rv, rpc, rdy);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 30'd0,         16'd0};
    tbl[1]  = '{0, 32'h0,        1, 1, 32'h0,        32'hA000_0000, 0, 30'd1,         16'd0};
    tbl[2]  = '{0, 32'h0,        1, 1, 32'h4,        32'hA000_0001, 0, 30'd2,         16'd0};
    tbl[3]  = '{0, 32'h0,        0, 1, 32'h8,        32'hA000_0002, 0, 30'd2,         16'd0};
    tbl[4]  = '{0, 32'h0,        0, 1, 32'h8,        32'hA000_0002, 0, 30'd2,         16'd1};
    tbl[5]  = '{0, 32'h0,        0, 1, 32'h8,        32'hA000_0002, 0, 30'd2,         16'd2};
    tbl[6]  = '{0, 32'h0,        1, 1, 32'h8,        32'hA000_0002, 0, 30'd3,         16'd3};
    tbl[7]  = '{0, 32'h0,        1, 1, 32'hC,        32'hA000_0003, 0, 30'd4,         16'd3};
    tbl[8]  = '{1, 32'h4,        1, 0, 32'h10,       32'h0,        0, 30'd1,         16'd3};
    tbl[9]  = '{1, 32'h13,       1, 0, 32'h4,        32'h0,        0, 30'd4,         16'd3};
    tbl[10] = '{0, 32'h0,        1, 1, 32'h10,       32'hA000_0004, 0, 30'd5,         16'd3};
    tbl[11] = '{0, 32'h0,        0, 1, 32'h14,       32'hA000_0005, 0, 30'd5,         16'd3};
    tbl[12] = '{1, 32'h40,       0, 0, 32'h14,       32'h0,        0, 30'd16,        16'd4};
    tbl[13] = '{0, 32'h0,        1, 1, 32'h40,       32'hA000_0010, 0, 30'd17,        16'd4};
    tbl[14] = '{0, 32'h0,        1, 1, 32'h44,       32'hA000_0011, 0, 30'd18,        16'd4};
    tbl[15] = '{1, 32'h7C,       1, 0, 32'h48,       32'h0,        0, 30'd31,        16'd4};
    tbl[16] = '{0, 32'h0,        1, 1, 32'h7C,       32'hA000_001F, 0, 30'd32,        16'd4};
    tbl[17] = '{0, 32'h0,        1, 1, 32'h80,       32'h0,        1, 30'd33,        16'd4};
    tbl[18] = '{1, 32'hFFFF_FFFF, 1, 0, 32'h84,      32'h0,        0, 30'h3FFF_FFFF, 16'd4};
    tbl[19] = '{0, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'h0,       1, 30'd0,         16'd4};
    tbl[20] = '{0, 32'h0,        1, 1, 32'h0,        32'hA000_0000, 0, 30'd1,         16'd4};
    tbl[21] = '{0, 32'h0,        1, 1, 32'h4,        32'hA000_0001, 0, 30'd2,         16'd4};

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    m_reset();

    // Held in reset across a few edges
    repeat (3) @(negedge clk);
    chk("rst id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst id_fault", {31'd0, bus.id_fault}, 32'd0);
    chk("rst imem_addr", {2'b00, bus.imem_addr}, 32'd0);
    chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;

    // Directed table: stream, stall, redirects, fault boundary, wrap
    for (int i = 0; i < 22; i++) begin
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc    = tbl[i].rpc;
      bus.id_ready       = tbl[i].rdy;
      #1;
      chk_out(tbl[i].ev, tbl[i].epc, tbl[i].einstr, tbl[i].efault, tbl[i].eaddr, tbl[i].est);
      m_edge(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      @(negedge clk);
    end

    // Random stream against the reference
    for (int i = 0; i < 400; i++) begin
      logic        rv, rdy;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 4) != 0) ? ($urandom_range(0, 47) * 4 + $urandom_range(0, 3))
                                        : $urandom;
      step(rv, rpc, rdy, 1'b1);

      // Asynchronous reset between edges partway through
      if (i == 200) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("mid rst imem_addr", {2'b00, bus.imem_addr}, 32'd0);
        chk("mid rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
